// File: rtl/alu_pkg.sv
// Shared definitions for the bit-slice ALU blocks: default datapath width and
// the FSM state encoding used by the serial arithmetic units.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/fs_1_bit.sv
// Gate-level 1-bit full-subtractor slice: diff = a - b - b_in, with borrow out.
module fs_1_bit (
    output logic diff,
    output logic b_out,
    input  logic a,
    input  logic b,
    input  logic b_in
);

    assign diff  = a ^ b ^ b_in;
    assign b_out = (~a & b) | (~a & b_in) | (b & b_in);

endmodule

// File: rtl/serial_sub_n_bit.sv
// Bit-serial N-bit subtractor: computes a - b - b_in LSB first through a single
// full-subtractor slice, with a start/ready/busy/done handshake.
//
// Handshake: a request is taken on a rising edge where start=1 and ready=1;
// start is ignored otherwise. done pulses for one cycle once the result is
// complete, and diff/b_out/ovf stay valid until the next operation begins shifting.
module serial_sub_n_bit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    state_t           state_q,  state_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             b_out_q,  b_out_d;
    logic             ovf_q,    ovf_d;

    logic slice_d;
    logic slice_bo;

    fs_1_bit u_slice (
        .diff  (slice_d),
        .b_out (slice_bo),
        .a     (a_sr_q[0]),
        .b     (b_sr_q[0]),
        .b_in  (borrow_q)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        b_out_d  = b_out_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SHIFT;
                    a_sr_d   = a;
                    b_sr_d   = b;
                    borrow_d = b_in;
                    cnt_d    = '0;
                end
            end
            SHIFT: begin
                diff_d   = {slice_d, diff_q[WIDTH-1:1]};
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                borrow_d = slice_bo;
                cnt_d    = cnt_q + CW'(1);
                // On the MSB, borrow_q is the borrow into the sign bit.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    ovf_d   = borrow_q ^ slice_bo;
                    b_out_d = slice_bo;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            b_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            b_out_q  <= b_out_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q == SHIFT);
    assign done  = (state_q == DONE);
    assign diff  = diff_q;
    assign b_out = b_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_sub_n_bit.sv
// Directed and randomized checks of serial_sub_n_bit against an arithmetic
// reference model of a - b - b_in.
module tb_serial_sub_n_bit;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         b_in_i;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         b_out;
    logic         ovf;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic [W-1:0] prev_diff;
    logic         prev_bout;
    logic         prev_ovf;

    serial_sub_n_bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a_i),
        .b     (b_i),
        .b_in  (b_in_i),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .b_out (b_out),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         output logic [W-1:0] d, output logic bo, output logic ov);
        int ua, ub, sa, sb, r;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
        sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
        r  = ua - ub - int'(bin);
        d  = W'(r);
        bo = (ua < ub + int'(bin));
        r  = sa - sb - int'(bin);
        ov = (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
    endtask

    // Runs one operation accepted at the next edge k; ends #1 after edge k+9.
    // With noise set, extra start pulses land on edges k+3 and k+9.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          input logic noise);
        logic [W-1:0] ed;
        logic         eb, eo;
        int           base;
        model(a, b, bin, ed, eb, eo);
        @(negedge clk);
        start  = 1'b1;
        a_i    = a;
        b_i    = b;
        b_in_i = bin;
        base   = done_cnt;
        @(posedge clk); #1;
        start = 1'b0;
        a_i   = W'($urandom);
        b_i   = W'($urandom);
        chk("accept_busy", 32'(busy), 32'd1);
        chk("hold_diff", 32'(diff), 32'(prev_diff));
        chk("hold_bout", 32'(b_out), 32'(prev_bout));
        chk("hold_ovf", 32'(ovf), 32'(prev_ovf));
        for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            start = noise && (i == 3);
            if (noise) begin
                a_i    = W'($urandom);
                b_i    = W'($urandom);
                b_in_i = 1'($urandom);
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (i < W) begin
                chk("early_done", 32'(done), 32'd0);
                chk("shift_busy", 32'(busy), 32'd1);
            end
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_ready", 32'(ready), 32'd0);
        chk("diff", 32'(diff), 32'(ed));
        chk("b_out", 32'(b_out), 32'(eb));
        chk("ovf", 32'(ovf), 32'(eo));
        @(negedge clk);
        start = noise;
        a_i   = W'($urandom);
        b_i   = W'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
        chk("ready_back", 32'(ready), 32'd1);
        chk("done_cleared", 32'(done), 32'd0);
        chk("diff_stable", 32'(diff), 32'(ed));
        chk("one_done", 32'(done_cnt - base), 32'd1);
        prev_diff = ed;
        prev_bout = eb;
        prev_ovf  = eo;
    endtask

    initial begin
        int base;
        rst = 1'b1; start = 1'b0; a_i = '0; b_i = '0; b_in_i = 1'b0;
        prev_diff = '0; prev_bout = 1'b0; prev_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(b_out), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(8'h05, 8'h03, 1'b0, 1'b0);
        run_op(8'h03, 8'h05, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 1'b0);
        run_op(8'h7F, 8'hFF, 1'b0, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 1'b0);
        run_op(8'hA5, 8'h3C, 1'b1, 1'b1);
        // Accepted at edge k+10 of the previous operation.
        run_op(8'h12, 8'h34, 1'b0, 1'b0);

        // Reset in the middle of a shift.
        @(negedge clk);
        start = 1'b1; a_i = 8'h9C; b_i = 8'h21; b_in_i = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        base = done_cnt;
        @(posedge clk); #1;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_bout", 32'(b_out), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt - base), 32'd0);
        prev_diff = '0; prev_bout = 1'b0; prev_ovf = 1'b0;
        run_op(8'h9C, 8'h21, 1'b1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
